gpr_cdb_arbiter: RTL and testbench

Arbitrates the GPR common data bus among all result producers: ALU, FPU-to-GPR moves, the load/store unit's GPR load path, and others. Each producer raises a request with its ROB tag. The arbiter grants at most one per cycle, round-robin, and drives the registered broadcast (valid/tag/data) that reservation stations, the ROB and the load/store unit snoop the following cycle. Some producers (e.g. the load path) present their data one cycle after grant; the arbiter sources their data late.

---
 rtl/gpr_cdb_arbiter.sv | 143 ++++++++++++++
 tb/tb_gpr_cdb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_cdb_arbiter.sv
// gpr_cdb_arbiter: round-robin arbiter for the GPR common data bus.
// Grants at most one result producer per cycle and drives the registered
// broadcast (valid/tag/data) that consumers snoop the following cycle.
// Producers flagged in LATE_DATA_MASK present their data one cycle after
// grant; for those the broadcast data is muxed live from the requester.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      synchronous active-high reset
//   req_valid  per-requester request
//   req_ready  per-requester grant (combinational, one-hot or zero)
//   req_tag    packed ROB tags, requester i at [i*ROB_WIDTH +: ROB_WIDTH]
//   req_data   packed results, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   failure    misprediction flush, suppresses the grant this cycle
//   cdb_valid  broadcast valid (registered)
//   cdb_tag    broadcast tag (registered)
//   cdb_data   broadcast data (registered, or live for late requesters)
//
// Optional feature macro CDB_ARB_STATS_EN adds the saturating counters
// stat_grants and stat_conflicts.
module gpr_cdb_arbiter #(
  parameter int unsigned        N_REQ          = 4,
  parameter logic [N_REQ-1:0]   LATE_DATA_MASK = N_REQ'(4'b0100),
  parameter int unsigned        DATA_WIDTH     = 32,
  parameter int unsigned        ROB_WIDTH      = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*ROB_WIDTH-1:0]    req_tag,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                          failure,
  output logic                          cdb_valid,
  output logic [ROB_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_grants,
  output logic [31:0]                   stat_conflicts
`endif
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]      rr_ptr;
  logic                  cdb_valid_q;
  logic [ROB_WIDTH-1:0]  cdb_tag_q;
  logic [DATA_WIDTH-1:0] cdb_data_q;
  logic                  late_q;
  logic [PTR_W-1:0]      gidx_q;

  logic [ROB_WIDTH-1:0]  tag_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];

  logic [N_REQ-1:0]      grant_c;
  logic [PTR_W-1:0]      gidx_c;
  logic                  found_c;
  logic                  grant_any_c;
  logic [PTR_W-1:0]      next_ptr_c;

  // Unpack the flat request buses into per-requester arrays.
  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
    assign tag_arr[i]  = req_tag[i*ROB_WIDTH +: ROB_WIDTH];
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan starting at rr_ptr; index wraps explicitly so
  // non-power-of-2 requester counts stay in range.
  always_comb begin
    int unsigned sum;
    logic [PTR_W-1:0] idx;
    grant_c = '0;
    gidx_c  = '0;
    found_c = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = 32'(rr_ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = PTR_W'(sum);
      if (!found_c && req_valid[idx]) begin
        found_c      = 1'b1;
        gidx_c       = idx;
        grant_c[idx] = 1'b1;
      end
    end
  end

  // Reset and flush block the grant in the same cycle.
  assign req_ready   = (reset || failure) ? '0 : grant_c;
  assign grant_any_c = |req_ready;
  assign next_ptr_c  = (gidx_c == PTR_W'(N_REQ - 1)) ? '0 : gidx_c + PTR_W'(1);

  // Broadcast registers and priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      late_q      <= 1'b0;
      gidx_q      <= '0;
    end else if (grant_any_c) begin
      rr_ptr      <= next_ptr_c;
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= tag_arr[gidx_c];
      cdb_data_q  <= data_arr[gidx_c];
      late_q      <= LATE_DATA_MASK[gidx_c];
      gidx_q      <= gidx_c;
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  // Late producers register their result internally and present it live
  // in the broadcast cycle.
  assign cdb_data  = late_q ? data_arr[gidx_q] : cdb_data_q;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_grants_q;
  logic [31:0] stat_conflicts_q;

  // Saturating grant and multi-request-grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants_q    <= '0;
      stat_conflicts_q <= '0;
    end else if (grant_any_c) begin
      if (stat_grants_q != 32'hFFFF_FFFF)
        stat_grants_q <= stat_grants_q + 32'd1;
      if (($countones(req_valid) >= 2) && (stat_conflicts_q != 32'hFFFF_FFFF))
        stat_conflicts_q <= stat_conflicts_q + 32'd1;
    end
  end

  assign stat_grants    = stat_grants_q;
  assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Scoreboard bench for gpr_cdb_arbiter (N_REQ=4, requester 2 late).
module tb_gpr_cdb_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned RW  = 6;
  localparam int unsigned DW  = 32;
  localparam logic [3:0]  LATE = 4'b0100;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic            failure;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]     stat_grants;
  logic [31:0]     stat_conflicts;
`endif

  gpr_cdb_arbiter #(
    .N_REQ(N), .LATE_DATA_MASK(LATE), .DATA_WIDTH(DW), .ROB_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data), .failure(failure),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
`ifdef CDB_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [RW-1:0] tag;
    logic [DW-1:0] data;
    logic          late;
    int            g;
  } exp_t;

  exp_t          sb[$];
  logic [RW-1:0] tag_v [N];
  logic [DW-1:0] dat_v [N];
  int            m_ptr = 0;
  int            m_grants = 0;
  int            m_conflicts = 0;
  int            n_vec = 0;
  int            n_err = 0;

  // One clock of stimulus: apply at negedge, check the broadcast due from
  // the previous grant, check req_ready against the model, queue the next
  // expected broadcast.
  task automatic step(input logic [3:0] v, input logic f, input logic r);
    exp_t e, o;
    int g;
    logic [3:0] exp_rdy;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    req_valid = v; failure = f; reset = r;
    for (int i = 0; i < int'(N); i++) begin
      req_tag[i*RW +: RW]  = tag_v[i];
      req_data[i*DW +: DW] = dat_v[i];
    end
    #1;
    if (sb.size() > 0) begin
      o = sb.pop_front();
      n_vec++;
      if (cdb_valid !== o.v) begin
        n_err++; $display("FAIL cdb_valid: got %b want %b at %0t", cdb_valid, o.v, $time);
      end
      if (o.v) begin
        exp_d = o.late ? dat_v[o.g] : o.data;
        n_vec++;
        if (cdb_tag !== o.tag) begin
          n_err++; $display("FAIL cdb_tag: got %0d want %0d at %0t", cdb_tag, o.tag, $time);
        end
        n_vec++;
        if (cdb_data !== exp_d) begin
          n_err++; $display("FAIL cdb_data: got %h want %h at %0t", cdb_data, exp_d, $time);
        end
      end else begin
        n_vec++;
        if ($isunknown(cdb_tag) || $isunknown(cdb_data)) begin
          n_err++; $display("FAIL cdb_idle_x: tag %h data %h want known at %0t", cdb_tag, cdb_data, $time);
        end
      end
    end
`ifdef CDB_ARB_STATS_EN
    n_vec++;
    if (stat_grants !== 32'(m_grants) || stat_conflicts !== 32'(m_conflicts)) begin
      n_err++; $display("FAIL stats: got %0d/%0d want %0d/%0d", stat_grants, stat_conflicts, m_grants, m_conflicts);
    end
`endif
    g = -1;
    if (!f && !r)
      for (int k = 0; k < int'(N); k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    n_vec++;
    if (req_ready !== exp_rdy) begin
      n_err++; $display("FAIL req_ready: got %b want %b at %0t", req_ready, exp_rdy, $time);
    end
    e.v    = (g >= 0);
    e.g    = (g >= 0) ? g : 0;
    e.tag  = tag_v[e.g];
    e.data = dat_v[e.g];
    e.late = LATE[e.g];
    sb.push_back(e);
    if (r) begin
      m_ptr = 0; m_grants = 0; m_conflicts = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_grants++;
      if ($countones(v) >= 2) m_conflicts++;
    end
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    tag_v[0] = 6'd5; dat_v[0] = 32'h1234;
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // pointer now 1: requester 0 and 1 valid must pick 1
    tag_v[1] = 6'd7; dat_v[1] = 32'h5555_0001;
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      tag_v[i] = RW'(10 + i); dat_v[i] = 32'hA000_0000 + 32'(i);
    end
    for (int c = 0; c < 5; c++) step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
`ifdef CDB_ARB_STATS_EN
    n_vec++;
    if (stat_conflicts !== 32'd5) begin
      n_err++; $display("FAIL rr_conflicts: got %0d want 5", stat_conflicts);
    end
`endif
  endtask

  task automatic test_late();
    do_reset();
    tag_v[2] = 6'd9; dat_v[2] = 32'h0;
    step(4'b0100, 1'b0, 1'b0);
    dat_v[2] = 32'hDEAD_BEEF;
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    tag_v[2] = 6'd3; dat_v[2] = 32'h0;
    step(4'b0100, 1'b0, 1'b0);
    tag_v[2] = 6'd4; dat_v[2] = 32'h1111_1111;
    step(4'b0100, 1'b0, 1'b0);
    dat_v[2] = 32'h2222_2222;
    step(4'b0000, 1'b0, 1'b0);
    // non-late requester alone, granted two cycles running
    tag_v[1] = 6'd21; dat_v[1] = 32'h3333_3333;
    step(4'b0010, 1'b0, 1'b0);
    tag_v[1] = 6'd22; dat_v[1] = 32'h4444_4444;
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_failure();
    do_reset();
    tag_v[0] = 6'd1; dat_v[0] = 32'hF0;
    tag_v[1] = 6'd2; dat_v[1] = 32'hF1;
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    // flush right after a grant: registered broadcast still appears
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      tag_v[i] = RW'(30 + i); dat_v[i] = 32'hC000_0000 + 32'(i);
    end
    step(4'b0111, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        tag_v[i] = RW'($urandom);
        dat_v[i] = $urandom;
      end
      step(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0));
    end
    step(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; failure = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      tag_v[i] = '0; dat_v[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_late();
    test_back_to_back();
    test_failure();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
